// File: rtl/regfile_scoreboard.sv
// DEPTH x WIDTH register file with two combinational read ports, one write port,
// r0 hardwired to zero, optional write bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wr_ok, rsv_ok, cnt_inc, cnt_dec, byp_a, byp_b;

  assign wr_ok  = we && (waddr != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  // A reservation on the written address wins, so that write never releases it.
  assign cnt_inc = rsv_ok && !pending[rsv_addr];
  assign cnt_dec = wr_ok && pending[waddr] && !(rsv_ok && (rsv_addr == waddr));

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_ok)  pending[waddr]    <= 1'b0;
      if (rsv_ok) pending[rsv_addr] <= 1'b1;
      if (cnt_inc && !cnt_dec)      pending_cnt <= pending_cnt + CNT_ONE;
      else if (cnt_dec && !cnt_inc) pending_cnt <= pending_cnt - CNT_ONE;
    end
  end

  assign byp_a = BYPASS && we && (waddr == raddr_a);
  assign byp_b = BYPASS && we && (waddr == raddr_b);

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) rdata_a = byp_a ? wdata : regs[raddr_a];
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) rdata_b = byp_b ? wdata : regs[raddr_b];
  end

  // pending[0] is never set, so address 0 reads as not busy.
  assign busy_a = pending[raddr_a] && !byp_a;
  assign busy_b = pending[raddr_b] && !byp_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing register file driven by the
// same stimulus, each checked against hand-computed values.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        clr, we, rsv_en;
  logic [4:0]  waddr, raddr_a, raddr_b, rsv_addr;
  logic [31:0] wdata;

  logic [31:0] rd_a_byp, rd_b_byp, rd_a_nb, rd_b_nb;
  logic        busy_a_byp, busy_b_byp, busy_a_nb, busy_b_nb;
  logic [5:0]  cnt_byp, cnt_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a_byp), .rdata_b(rd_b_byp),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a_byp), .busy_b(busy_b_byp),
    .pending_cnt(cnt_byp)
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a_nb), .rdata_b(rd_b_nb),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a_nb), .busy_b(busy_b_nb),
    .pending_cnt(cnt_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drop all requests so the next cycle starts idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr = 1'b0; we = 1'b0; rsv_en = 1'b0;
    waddr = '0; wdata = '0; rsv_addr = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; rsv_en = 1'b0;
    waddr = '0; wdata = '0; rsv_addr = '0; raddr_a = '0; raddr_b = '0;
    tick();

    // reset state
    settle();
    check("rst_cnt_byp", 32'(cnt_byp), 32'd0);
    check("rst_cnt_nb",  32'(cnt_nb),  32'd0);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      settle();
      check("rst_rd_a_byp", rd_a_byp, 32'd0);
      check("rst_rd_b_nb",  rd_b_nb,  32'd0);
      check("rst_busy_a_byp", 32'(busy_a_byp), 32'd0);
      check("rst_busy_b_nb",  32'(busy_b_nb),  32'd0);
    end

    // write r5, both ports read r5 in the write cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5; raddr_b = 5'd5;
    settle();
    check("wr5_same_a_byp", rd_a_byp, 32'hDEADBEEF);
    check("wr5_same_b_byp", rd_b_byp, 32'hDEADBEEF);
    check("wr5_same_a_nb",  rd_a_nb,  32'd0);
    tick(); settle();
    check("wr5_next_a_byp", rd_a_byp, 32'hDEADBEEF);
    check("wr5_next_a_nb",  rd_a_nb,  32'hDEADBEEF);
    check("wr5_next_b_nb",  rd_b_nb,  32'hDEADBEEF);

    // write and reserve r0 are ignored
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; rsv_en = 1'b1; rsv_addr = 5'd0;
    raddr_a = 5'd0; raddr_b = 5'd0;
    settle();
    check("r0_same_byp", rd_a_byp, 32'd0);
    tick(); settle();
    check("r0_rd_byp",   rd_a_byp, 32'd0);
    check("r0_rd_nb",    rd_b_nb,  32'd0);
    check("r0_busy_byp", 32'(busy_a_byp), 32'd0);
    check("r0_cnt_byp",  32'(cnt_byp), 32'd0);
    check("r0_cnt_nb",   32'(cnt_nb),  32'd0);

    // reserve r3 then r7
    rsv_en = 1'b1; rsv_addr = 5'd3; raddr_a = 5'd3; raddr_b = 5'd7;
    settle();
    check("rsv3_nocomb_byp", 32'(busy_a_byp), 32'd0);
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    settle();
    check("rsv3_busy_byp", 32'(busy_a_byp), 32'd1);
    check("rsv3_busy_nb",  32'(busy_a_nb),  32'd1);
    check("rsv7_pre_byp",  32'(busy_b_byp), 32'd0);
    check("rsv3_cnt_byp",  32'(cnt_byp), 32'd1);
    tick(); settle();
    check("rsv7_busy_byp", 32'(busy_b_byp), 32'd1);
    check("rsv7_busy_nb",  32'(busy_b_nb),  32'd1);
    check("rsv7_cnt_byp",  32'(cnt_byp), 32'd2);
    check("rsv7_cnt_nb",   32'(cnt_nb),  32'd2);

    // release r3 by write
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    settle();
    check("wr3_same_busy_byp", 32'(busy_a_byp), 32'd0);
    check("wr3_same_busy_nb",  32'(busy_a_nb),  32'd1);
    check("wr3_same_cnt_byp",  32'(cnt_byp), 32'd2);
    tick(); settle();
    check("wr3_busy_nb",  32'(busy_a_nb), 32'd0);
    check("wr3_data_nb",  rd_a_nb, 32'h0000_0033);
    check("wr3_cnt_byp",  32'(cnt_byp), 32'd1);
    check("wr3_cnt_nb",   32'(cnt_nb),  32'd1);
    check("wr3_r7_busy",  32'(busy_b_byp), 32'd1);

    // reserve r9, then reserve+write r9 together: reservation wins
    rsv_en = 1'b1; rsv_addr = 5'd9; raddr_a = 5'd9; raddr_b = 5'd4;
    tick(); settle();
    check("rsv9_cnt_byp", 32'(cnt_byp), 32'd2);
    rsv_en = 1'b1; rsv_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
    settle();
    check("rw9_same_busy_byp", 32'(busy_a_byp), 32'd0);
    check("rw9_same_busy_nb",  32'(busy_a_nb),  32'd1);
    tick(); settle();
    check("rw9_busy_byp", 32'(busy_a_byp), 32'd1);
    check("rw9_busy_nb",  32'(busy_a_nb),  32'd1);
    check("rw9_data_nb",  rd_a_nb, 32'h0000_0099);
    check("rw9_cnt_byp",  32'(cnt_byp), 32'd2);
    check("rw9_cnt_nb",   32'(cnt_nb),  32'd2);

    // reserve r4 while writing pending r9: net zero
    rsv_en = 1'b1; rsv_addr = 5'd4; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0999;
    tick(); settle();
    check("r4w9_cnt_byp",  32'(cnt_byp), 32'd2);
    check("r4w9_cnt_nb",   32'(cnt_nb),  32'd2);
    check("r4w9_busy9",    32'(busy_a_nb), 32'd0);
    check("r4w9_busy4",    32'(busy_b_byp), 32'd1);

    // unreserved write and re-reserving a pending register leave count unchanged
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0C0C; rsv_en = 1'b1; rsv_addr = 5'd7;
    raddr_a = 5'd12; raddr_b = 5'd7;
    tick(); settle();
    check("w12_busy_nb",  32'(busy_a_nb), 32'd0);
    check("w12_data_byp", rd_a_byp, 32'h0000_0C0C);
    check("rr7_busy_byp", 32'(busy_b_byp), 32'd1);
    check("rr7_cnt_byp",  32'(cnt_byp), 32'd2);
    check("rr7_cnt_nb",   32'(cnt_nb),  32'd2);

    // clr dominates a same-cycle reservation and write
    clr = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd2; we = 1'b1; waddr = 5'd10; wdata = 32'hA5A5A5A5;
    raddr_a = 5'd10; raddr_b = 5'd2;
    tick(); settle();
    check("clr_r10_byp",  rd_a_byp, 32'd0);
    check("clr_r10_nb",   rd_a_nb,  32'd0);
    check("clr_busy2_byp", 32'(busy_b_byp), 32'd0);
    check("clr_busy2_nb",  32'(busy_b_nb),  32'd0);
    check("clr_cnt_byp",  32'(cnt_byp), 32'd0);
    check("clr_cnt_nb",   32'(cnt_nb),  32'd0);
    raddr_a = 5'd5; raddr_b = 5'd7;
    settle();
    check("clr_r5_nb",    rd_a_nb, 32'd0);
    check("clr_busy7_byp", 32'(busy_b_byp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
